// File: rtl/keypad_pkg.sv
// Shared key codes, FSM encoding and the reverse double-dabble step for keypad_entry.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_BACKSPACE = 4'hB;
  localparam logic [3:0] KEY_ENTER     = 4'hC;

  localparam int CONV_ITER = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_CONV  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One iteration on the {bcd[11:0], bin[11:0]} pair: shift right, then pull every BCD nibble >= 8 down by 3.
  function automatic logic [23:0] dabble_step(input logic [23:0] pair);
    logic [23:0] s;
    s = pair >> 1;
    for (int i = 0; i < 3; i++) begin
      if (s[12+4*i +: 4] >= 4'd8) s[12+4*i +: 4] = s[12+4*i +: 4] - 4'd3;
    end
    return s;
  endfunction

endpackage

// File: rtl/bcd2binary_seq.sv
// Iterative 3-digit BCD to binary converter; the first step happens on the start edge so
// the done strobe sits in the twelfth cycle and the result is final while it is high.
module bcd2binary_seq
  import keypad_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] bcd,
  output logic [9:0]  binary,
  output logic        done
);

  logic [23:0] pair;
  logic [3:0]  iter_left;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pair      <= '0;
      iter_left <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        pair      <= dabble_step({bcd, 12'd0});
        iter_left <= 4'(CONV_ITER - 1);
      end else if (iter_left != 4'd0) begin
        pair      <= dabble_step(pair);
        iter_left <= iter_left - 4'd1;
        done      <= (iter_left == 4'd1);
      end
    end
  end

  assign binary = pair[9:0];

endmodule

// File: rtl/keypad_entry.sv
// Keypad digit entry with BCD display and binary conversion on enter.
// Define KEYPAD_BACKSPACE_EN to make 0xB act as backspace while digits are held.
//
//  state    | meaning
//  ST_IDLE  | no digits held
//  ST_ENTRY | 1..MAX_DIGITS digits held
//  ST_CONV  | converter running, keys discarded
//  ST_DONE  | value_valid strobe, entry cleared on exit
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int MAX_DIGITS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key_value,
  input  logic        key_valid,
  output logic [11:0] bcd,
  output logic [1:0]  digit_count,
  output logic        busy,
  output logic [9:0]  value,
  output logic        value_valid,
  output logic        overflow
);

  state_t      state, state_n;
  logic [11:0] bcd_n;
  logic [1:0]  count_n;
  logic        ovf_n;
  logic        start;
  logic        key_digit;
  logic [9:0]  conv_bin;
  logic        conv_done;

  assign key_digit = key_valid && (key_value <= 4'd9);
  assign busy      = (state == ST_CONV) || (state == ST_DONE);

  always_comb begin
    state_n = state;
    bcd_n   = bcd;
    count_n = digit_count;
    ovf_n   = overflow;
    start   = 1'b0;
    case (state)
      ST_IDLE, ST_ENTRY: begin
        if (key_digit) begin
          if (digit_count == 2'(MAX_DIGITS)) begin
            ovf_n = 1'b1;
          end else begin
            bcd_n   = {bcd[7:0], key_value};
            count_n = digit_count + 2'd1;
            state_n = ST_ENTRY;
          end
        end else if (key_valid && key_value == KEY_CLEAR) begin
          bcd_n   = '0;
          count_n = '0;
          ovf_n   = 1'b0;
          state_n = ST_IDLE;
        end else if (key_valid && key_value == KEY_ENTER && state == ST_ENTRY) begin
          start   = 1'b1;
          state_n = ST_CONV;
        end
`ifdef KEYPAD_BACKSPACE_EN
        else if (key_valid && key_value == KEY_BACKSPACE && state == ST_ENTRY) begin
          bcd_n   = {4'd0, bcd[11:4]};
          count_n = digit_count - 2'd1;
          ovf_n   = 1'b0;
          if (digit_count == 2'd1) state_n = ST_IDLE;
        end
`endif
      end
      ST_CONV: begin
        if (conv_done) state_n = ST_DONE;
      end
      ST_DONE: begin
        bcd_n   = '0;
        count_n = '0;
        ovf_n   = 1'b0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      bcd         <= '0;
      digit_count <= '0;
      overflow    <= 1'b0;
      value       <= '0;
      value_valid <= 1'b0;
    end else begin
      state       <= state_n;
      bcd         <= bcd_n;
      digit_count <= count_n;
      overflow    <= ovf_n;
      value_valid <= (state == ST_CONV) && conv_done;
      if ((state == ST_CONV) && conv_done) value <= conv_bin;
    end
  end

  bcd2binary_seq u_conv (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bcd    (bcd),
    .binary (conv_bin),
    .done   (conv_done)
  );

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a default 3-digit instance and a MAX_DIGITS=1 instance.
module tb_keypad_entry;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_value, k1_value;
  logic        key_valid, k1_valid;
  logic [11:0] bcd, bcd1;
  logic [1:0]  digit_count, digit_count1;
  logic        busy, busy1;
  logic [9:0]  value, value1;
  logic        value_valid, value_valid1;
  logic        overflow, overflow1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    logic [9:0] v;
  } exp_t;
  exp_t sb[$];

  keypad_entry dut (
    .clk(clk), .reset(reset), .key_value(key_value), .key_valid(key_valid),
    .bcd(bcd), .digit_count(digit_count), .busy(busy), .value(value),
    .value_valid(value_valid), .overflow(overflow)
  );

  keypad_entry #(.MAX_DIGITS(1)) dut1 (
    .clk(clk), .reset(reset), .key_value(k1_value), .key_valid(k1_valid),
    .bcd(bcd1), .digit_count(digit_count1), .busy(busy1), .value(value1),
    .value_valid(value_valid1), .overflow(overflow1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Caller is always at a falling edge; the key is sampled on the following rising edge.
  task automatic press(input logic [3:0] k);
    key_value = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic press1(input logic [3:0] k);
    k1_value = k;
    k1_valid = 1'b1;
    @(negedge clk);
    k1_valid = 1'b0;
  endtask

  task automatic press_enter(input logic [9:0] v, input bit expect_result);
    if (expect_result) sb.push_back('{cyc + 13, v});
    press(KEY_ENTER);
  endtask

  // Result monitor: a strobe must appear exactly on the expected cycle and nowhere else.
  always @(negedge clk) begin
    if (reset) begin
      if (sb.size() > 0 && cyc == sb[0].due) begin
        chk("value_valid_at_13", 32'(value_valid), 32'd1);
        chk("value", 32'(value), 32'(sb[0].v));
        void'(sb.pop_front());
      end else if (value_valid) begin
        chk("unexpected_value_valid", 32'(value_valid), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    key_value = 4'd0; key_valid = 1'b0;
    k1_value  = 4'd0; k1_valid  = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_count", 32'(digit_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_vv", 32'(value_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1,2,3,enter -> 123; keys during busy are dropped and bcd holds
    press(4'd1); press(4'd2); press(4'd3);
    chk("bcd_123", 32'(bcd), 32'h123);
    chk("count_3", 32'(digit_count), 32'd3);
    press_enter(10'd123, 1'b1);
    chk("busy_conv", 32'(busy), 32'd1);
    press(4'd7);
    chk("bcd_stable_busy", 32'(bcd), 32'h123);
    press(KEY_CLEAR);
    chk("clear_ignored_busy", 32'(digit_count), 32'd3);
    repeat (12) @(negedge clk);
    chk("after_done_bcd", 32'(bcd), 32'h0);
    chk("after_done_count", 32'(digit_count), 32'd0);
    chk("after_done_busy", 32'(busy), 32'd0);
    chk("value_held_123", 32'(value), 32'd123);

    // 9,9,9,4 -> overflow, 999
    press(4'd9); press(4'd9); press(4'd9); press(4'd4);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("bcd_999", 32'(bcd), 32'h999);
    press(4'hE);
    chk("unused_code", 32'(bcd), 32'h999);
    press_enter(10'd999, 1'b1);
    repeat (14) @(negedge clk);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // 5,clear,7,enter -> 7; clear leaves value alone
    press(4'd5); press(KEY_CLEAR);
    chk("clear_bcd", 32'(bcd), 32'h0);
    chk("clear_keeps_value", 32'(value), 32'd999);
    press(4'd7);
    chk("bcd_7", 32'(bcd), 32'h007);
    press_enter(10'd7, 1'b1);
    repeat (14) @(negedge clk);

    // enter with no digits does nothing
    press_enter(10'd0, 1'b0);
    chk("idle_enter_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_enter_busy_later", 32'(busy), 32'd0);

    // 4,2,backspace,8,enter
    press(4'd4); press(4'd2); press(KEY_BACKSPACE);
`ifdef KEYPAD_BACKSPACE_EN
    chk("bksp_bcd", 32'(bcd), 32'h004);
    chk("bksp_count", 32'(digit_count), 32'd1);
    press(4'd8);
    chk("bcd_48", 32'(bcd), 32'h048);
    press_enter(10'd48, 1'b1);
    repeat (14) @(negedge clk);
    press(4'd3); press(KEY_BACKSPACE);
    chk("bksp_to_zero", 32'(digit_count), 32'd0);
    press_enter(10'd0, 1'b0);
    chk("bksp_idle_enter", 32'(busy), 32'd0);
`else
    chk("no_bksp_bcd", 32'(bcd), 32'h042);
    chk("no_bksp_count", 32'(digit_count), 32'd2);
    press(4'd8);
    chk("bcd_428", 32'(bcd), 32'h428);
    press_enter(10'd428, 1'b1);
    repeat (14) @(negedge clk);
    press(KEY_BACKSPACE);
    chk("bksp_idle_ignored", 32'(digit_count), 32'd0);
`endif

    // reset in CONV cycle 6 aborts the result
    press(4'd6); press(4'd5);
    press_enter(10'd0, 1'b0);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd), 32'h0);
    chk("abort_count", 32'(digit_count), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_value", 32'(value), 32'd0);
    chk("abort_vv", 32'(value_valid), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_value_later", 32'(value), 32'd0);

    // MAX_DIGITS=1: 3,6,enter -> overflow and 3
    press1(4'd3); press1(4'd6);
    chk("m1_ovf", 32'(overflow1), 32'd1);
    chk("m1_bcd", 32'(bcd1), 32'h003);
    k1_value = KEY_ENTER; k1_valid = 1'b1;
    @(negedge clk);
    k1_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("m1_vv_early", 32'(value_valid1), 32'd0);
    @(negedge clk);
    chk("m1_vv", 32'(value_valid1), 32'd1);
    chk("m1_value", 32'(value1), 32'd3);
    @(negedge clk);
    chk("m1_vv_one_cycle", 32'(value_valid1), 32'd0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
